fmul_share_arb: RTL and testbench

Round-robin arbiter that shares one pipelined single-precision floating-point multiplier (`multtop`: clk, reset, valid_in, valid_out, in0, in1, out0) between NREQ independent requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one product per cycle. It records the issuing requester in an in-order tag FIFO, then steers each multiplier result back to its originator. It sits between the compute clients and the single multiplier instance, and the multiplier shares its clock and reset.

---
 rtl/fmul_share_arb.sv | 151 +++++++++++++++
 tb/tb_fmul_share_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_share_arb.sv
// rtl/fmul_share_arb.sv - round-robin arbiter sharing one pipelined FP multiplier
//
// Purpose: accepts operand pairs from NREQ requesters, issues at most one
// product per cycle to a single in-order multiplier, remembers the issuing
// requester in a tag FIFO, and steers each returning product back to it.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset (shared with multiplier)
//   req_valid/ready    per-requester handshake, ready is one-hot grant
//   req_a/req_b        packed operands, requester i at [32i+31:32i]
//   res_valid/res_data one-hot result strobe and product (no backpressure)
//   mul_valid_in/in0/in1  registered issue to the multiplier
//   mul_valid_out/out0    multiplier result
//   inflight           tag FIFO occupancy
//   err                sticky: multiplier returned a result with nothing in flight

module fmul_share_arb #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 16,
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   res_valid,
  output logic [31:0]       res_data,
  output logic              mul_valid_in,
  output logic [31:0]       mul_in0,
  output logic [31:0]       mul_in1,
  input  logic              mul_valid_out,
  input  logic [31:0]       mul_out0,
  output logic [CW-1:0]     inflight,
  output logic              err
);

  logic [TW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          mvi_q, mvi_d;
  logic [31:0]   in0_q, in0_d, in1_q, in1_d;
  logic [TW-1:0] tag_mem [DEPTH];

  logic          found;
  logic [TW-1:0] win;
  logic [TW:0]   scan;
  logic [31:0]   sel_a, sel_b;
  logic          full, push, pop;
  logic [TW-1:0] head_tag;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr_q} + (TW+1)'(k);
      if (scan >= (TW+1)'(NREQ)) begin
        scan = scan - (TW+1)'(NREQ);
      end
      if (!found && req_valid[scan[TW-1:0]]) begin
        found = 1'b1;
        win   = scan[TW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (TW'(k) == win) begin
        sel_a = req_a[32*k +: 32];
        sel_b = req_b[32*k +: 32];
      end
    end
  end

  // Full blocks grants even if a pop lands this cycle, so ready never
  // depends on mul_valid_out.
  assign full     = (cnt_q == CW'(DEPTH));
  assign push     = found & ~full & ~reset;
  assign head_tag = tag_mem[rd_q];
  assign pop      = mul_valid_out & (cnt_q != '0) & ~reset;

  assign req_ready = push ? (NREQ'(1) << win) : '0;
  assign res_valid = pop ? (NREQ'(1) << head_tag) : '0;
  assign res_data  = mul_out0;

  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = (win == TW'(NREQ - 1)) ? '0 : win + TW'(1);
    end
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (mul_valid_out & (cnt_q == '0));
    mvi_d = push;
    in0_d = push ? sel_a : '0;
    in1_d = push ? sel_b : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      mvi_q <= 1'b0;
      in0_q <= '0;
      in1_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      mvi_q <= mvi_d;
      in0_q <= in0_d;
      in1_q <= in1_d;
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
    end
  end

  // Tag storage needs no reset: entries are only read behind the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_q] <= win;
    end
  end

  assign mul_valid_in = mvi_q;
  assign mul_in0      = in0_q;
  assign mul_in1      = in1_q;
  assign inflight     = cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_fmul_share_arb.sv
// tb/tb_fmul_share_arb.sv - self-checking bench for fmul_share_arb
module tb_fmul_share_arb;
  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_ready, res_valid;
  logic [32*NREQ-1:0]   req_a, req_b;
  logic [31:0]          res_data, mul_in0, mul_in1, mul_out0;
  logic                 mul_valid_in, mul_valid_out;
  logic [CW-1:0]        inflight;
  logic                 err;

  always #5 clk = ~clk;

  fmul_share_arb #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_data(res_data),
    .mul_valid_in(mul_valid_in), .mul_in0(mul_in0), .mul_in1(mul_in1),
    .mul_valid_out(mul_valid_out), .mul_out0(mul_out0),
    .inflight(inflight), .err(err)
  );

  // Multiplier stand-in: fixed-latency pipeline, known products for table operands.
  function automatic logic [31:0] fmul_stub(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'hc0000000_418c0000: return 32'hc20c0000;
      64'hc0490fdb_402df854: return 32'hc108a2c0;
      64'h3f800000_40000000: return 32'h40000000;
      64'h3fc00000_3fc00000: return 32'h40100000;
      64'hbf800000_bf800000: return 32'h3f800000;
      default:               return a ^ {b[15:0], b[31:16]} ^ 32'h5a5a0000;
    endcase
  endfunction

  logic        pv [16];
  logic [31:0] pd [16];
  int          lat = 2;
  logic        force_stray;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= mul_valid_in;
      pd[0] <= fmul_stub(mul_in0, mul_in1);
      for (int k = 1; k < 16; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end
  assign mul_valid_out = pv[lat-1] | force_stray;
  assign mul_out0      = pd[lat-1];

  // Reference model: in-flight queue in issue order plus round-robin pointer.
  typedef struct { int req; logic [31:0] prod; } inflt_t;
  typedef struct { int req; logic [31:0] a; logic [31:0] b; logic [31:0] p; } vec_t;

  inflt_t      mq[$];
  logic [63:0] srcq [NREQ][$];
  int          m_ptr;
  logic        m_err, e_mvi;
  logic [31:0] e_in0, e_in1;
  logic [NREQ-1:0] gate;
  int          grant_log[$], grant_cyc[$], res_req[$];
  logic [31:0] res_dat[$];
  int          cyc;
  int          total = 0, bad = 0;
  vec_t        vt [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int w, idx;
    logic [NREQ-1:0] e_rdy, e_rv;
    logic pop;
    logic [31:0] a, b;
    w = -1;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && ((req_valid >> idx) & NREQ'(1)) != 0) w = idx;
      end
    end
    e_rdy = (w >= 0 && mq.size() < DEPTH && !reset) ? (NREQ'(1) << w) : '0;
    pop   = !reset && mul_valid_out && mq.size() != 0;
    e_rv  = pop ? (NREQ'(1) << mq[0].req) : '0;
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("res_valid", 64'(res_valid), 64'(e_rv));
    if (pop) chk("res_data", 64'(res_data), 64'(mq[0].prod));
    chk("mul_valid_in", 64'(mul_valid_in), 64'(e_mvi));
    chk("mul_in0", 64'(mul_in0), 64'(e_in0));
    chk("mul_in1", 64'(mul_in1), 64'(e_in1));
    chk("inflight", 64'(inflight), 64'(mq.size()));
    chk("err", 64'(err), 64'(m_err));
    for (int i = 0; i < NREQ; i++) begin
      if (((res_valid >> i) & NREQ'(1)) != 0) begin
        res_req.push_back(i);
        res_dat.push_back(res_data);
      end
    end
    if (reset) begin
      mq.delete();
      m_ptr = 0; m_err = 1'b0; e_mvi = 1'b0; e_in0 = '0; e_in1 = '0;
    end else begin
      if (mul_valid_out && mq.size() == 0) m_err = 1'b1;
      if (pop) void'(mq.pop_front());
      if (e_rdy != '0) begin
        a = req_a[32*w +: 32];
        b = req_b[32*w +: 32];
        mq.push_back('{w, fmul_stub(a, b)});
        m_ptr = (w + 1) % NREQ;
        e_mvi = 1'b1; e_in0 = a; e_in1 = b;
        void'(srcq[w].pop_front());
        grant_log.push_back(w);
        grant_cyc.push_back(cyc);
      end else begin
        e_mvi = 1'b0; e_in0 = '0; e_in1 = '0;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    logic [63:0] ent;
    for (int i = 0; i < NREQ; i++) begin
      if (srcq[i].size() != 0 && gate[i]) begin
        ent = srcq[i][0];
        req_valid[i] = 1'b1;
        req_a[32*i +: 32] = ent[63:32];
        req_b[32*i +: 32] = ent[31:0];
      end else begin
        req_valid[i] = 1'b0;
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
      end
    end
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit busy();
    for (int i = 0; i < NREQ; i++) if (srcq[i].size() != 0) return 1'b1;
    return mq.size() != 0;
  endfunction

  task automatic drain();
    int n = 0;
    while (busy() && n < 1000) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(busy()), 64'(0));
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete(); res_req.delete(); res_dat.delete();
    cyc = 0;
  endtask

  task automatic do_reset(input int new_lat);
    reset = 1'b1;
    cycle();
    lat = new_lat;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt [NREQ];
    int exp_cyc [8];
    int r;
    vt[0] = '{0, 32'hc0000000, 32'h418c0000, 32'hc20c0000};
    vt[1] = '{3, 32'hc0490fdb, 32'h402df854, 32'hc108a2c0};
    vt[2] = '{1, 32'h3f800000, 32'h40000000, 32'h40000000};
    vt[3] = '{2, 32'h3fc00000, 32'h3fc00000, 32'h40100000};
    vt[4] = '{1, 32'hbf800000, 32'hbf800000, 32'h3f800000};
    exp_cyc = '{0, 1, 2, 3, 12, 13, 14, 15};

    reset = 1'b1; force_stray = 1'b0; gate = '1;
    req_valid = '0; req_a = '0; req_b = '0;
    m_ptr = 0; m_err = 1'b0; e_mvi = 1'b0; e_in0 = '0; e_in1 = '0; cyc = 0;
    @(posedge clk);
    #1;
    srcq[2].push_back({32'h3f800000, 32'h40000000});
    cycle();
    cycle();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_mvi", 64'(mul_valid_in), 64'(0));
    void'(srcq[2].pop_front());
    reset = 1'b0;

    // Table-driven single transactions
    foreach (vt[k]) begin
      srcq[vt[k].req].push_back({vt[k].a, vt[k].b});
      clear_logs();
      drain();
      chk("vec_count", 64'(res_req.size()), 64'(1));
      if (res_req.size() == 1) begin
        chk("vec_tag", 64'(res_req[0]), 64'(vt[k].req));
        chk("vec_data", 64'(res_dat[0]), 64'(vt[k].p));
      end
      chk("vec_inflight", 64'(inflight), 64'(0));
      chk("vec_err", 64'(err), 64'(0));
    end

    // Two requesters presenting together
    do_reset(2);
    srcq[1].push_back({32'hc0490fdb, 32'h402df854});
    srcq[2].push_back({32'hc0000000, 32'h418c0000});
    clear_logs();
    drain();
    chk("two_grants", 64'(grant_log.size()), 64'(2));
    chk("two_results", 64'(res_req.size()), 64'(2));
    if (grant_log.size() == 2 && res_req.size() == 2) begin
      chk("two_g0", 64'(grant_log[0]), 64'(1));
      chk("two_g1", 64'(grant_log[1]), 64'(2));
      chk("two_r0", 64'(res_req[0]), 64'(1));
      chk("two_d0", 64'(res_dat[0]), 64'(32'hc108a2c0));
      chk("two_r1", 64'(res_req[1]), 64'(2));
      chk("two_d1", 64'(res_dat[1]), 64'(32'hc20c0000));
    end

    // Fairness: all four continuously valid for 40 cycles
    do_reset(2);
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 10; j++) srcq[i].push_back({$urandom, $urandom});
    clear_logs();
    repeat (40) cycle();
    chk("fair_total", 64'(grant_log.size()), 64'(40));
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    foreach (grant_log[k]) begin
      cnt[grant_log[k]]++;
      chk("fair_order", 64'(grant_log[k]), 64'(k % NREQ));
    end
    for (int i = 0; i < NREQ; i++) chk("fair_count", 64'(cnt[i]), 64'(10));
    drain();

    // Full FIFO with a slow multiplier
    do_reset(10);
    for (int i = 0; i < 8; i++) srcq[i % NREQ].push_back({$urandom, $urandom});
    clear_logs();
    repeat (6) cycle();
    chk("full_inflight", 64'(inflight), 64'(4));
    chk("full_ready", 64'(req_ready), 64'(0));
    drain();
    chk("full_grants", 64'(grant_cyc.size()), 64'(8));
    chk("full_results", 64'(res_req.size()), 64'(8));
    if (grant_cyc.size() == 8)
      for (int k = 0; k < 8; k++) chk("full_issue_cycle", 64'(grant_cyc[k]), 64'(exp_cyc[k]));

    // Reset while products are in flight
    for (int i = 0; i < 3; i++) srcq[i].push_back({$urandom, $urandom});
    clear_logs();
    repeat (3) cycle();
    chk("mid_pre_inflight", 64'(inflight), 64'(3));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_inflight", 64'(inflight), 64'(0));
    chk("mid_err", 64'(err), 64'(0));
    clear_logs();
    repeat (20) cycle();
    chk("mid_no_result", 64'(res_req.size()), 64'(0));
    chk("mid_err_after", 64'(err), 64'(0));
    srcq[3].push_back({32'h3f800000, 32'h40000000});
    clear_logs();
    drain();
    chk("mid_new_count", 64'(res_req.size()), 64'(1));
    if (res_req.size() == 1) begin
      chk("mid_new_tag", 64'(res_req[0]), 64'(3));
      chk("mid_new_data", 64'(res_dat[0]), 64'(32'h40000000));
    end

    // Stray multiplier result with nothing in flight
    clear_logs();
    force_stray = 1'b1;
    cycle();
    force_stray = 1'b0;
    chk("stray_err", 64'(err), 64'(1));
    repeat (3) cycle();
    chk("stray_hold", 64'(err), 64'(1));
    chk("stray_no_result", 64'(res_req.size()), 64'(0));

    // Randomized traffic against the model
    do_reset($urandom_range(1, 6));
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, NREQ - 1);
        if (srcq[r].size() < 4) srcq[r].push_back({$urandom, $urandom});
      end
      gate = NREQ'($urandom);
      cycle();
    end
    gate = '1;
    drain();
    chk("rand_inflight", 64'(inflight), 64'(0));
    chk("rand_err", 64'(err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
